otter_fetch_stage: RTL and testbench
====================================

Name: otter_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the dual-port BRAM's instruction port (port 1).
- Owns the PC and drives the BRAM address and read enable.
- Pairs the 1-cycle-latency BRAM instruction word with its PC and a valid bit, then hands the result to decode.
- Handles pipeline stalls, branch/trap redirects and fetch-fault detection.

Parameters:
- RESET_VEC, 32'h0000_0000, first PC fetched after reset.
- MEM_WIDTH, 18, word-address width of the BRAM. Byte space is 2**(MEM_WIDTH+2) bytes.

Ports:
- CLK, input, 1, sole clock, rising edge.
- RST, input, 1, reset, asynchronous, active-high.
- STALL, input, 1, decode cannot accept; hold the current output.
- REDIRECT, input, 1, load a new PC (branch/jump/trap); the current output is squashed.
- REDIRECT_PC, input, 32, target PC, sampled when REDIRECT=1.
- MEM_ADDR1, output, 32, BRAM port-1 byte address.
- MEM_READ1, output, 1, BRAM port-1 read enable.
- MEM_DOUT1, input, 32, BRAM port-1 data. Registered in the BRAM; it changes only on an edge with MEM_READ1=1.
- IF_PC, output, 32, PC of the instruction presented on IF_IR.
- IF_PC4, output, 32, IF_PC+4.
- IF_IR, output, 32, instruction word to decode.
- IF_VALID, output, 1, IF_IR/IF_PC are a live instruction.
- IF_FAULT, output, 1, fetch exception on the presented instruction.
- IF_CAUSE, output, 1, 0 = misaligned, 1 = access fault. Meaningful only when IF_FAULT=1.

Behaviour:
- Registers:
  - pc_q: next PC to issue.
  - ifpc_q: PC of the data now on MEM_DOUT1.
  - valid_q, fault_q, cause_q.
- Clock and reset: all registers are on CLK and reset asynchronously by RST.
- Reset values: pc_q=RESET_VEC, ifpc_q=0, valid_q=0, fault_q=0, cause_q=0.
- Outputs while RST=1: MEM_READ1=0, IF_VALID=0, IF_FAULT=0, IF_PC=0, IF_IR=32'h0000_0013 (NOP).
- Combinational issue logic:
  - MEM_ADDR1 = REDIRECT ? REDIRECT_PC : pc_q.
  - issue = !RST & (REDIRECT | !STALL).
  - MEM_READ1 = issue.
- On an edge with issue=1:
  - pc_q <= MEM_ADDR1+4, wrapping mod 2**32.
  - ifpc_q <= MEM_ADDR1.
  - valid_q <= 1.
- Fault check on the issued address:
  - misaligned if MEM_ADDR1[1:0]!=0;
  - access fault if MEM_ADDR1 >= 2**(MEM_WIDTH+2);
  - misaligned takes priority;
  - fault_q/cause_q are set accordingly, else cleared.
- On an edge with issue=0 (stalled, no redirect): every register holds. MEM_DOUT1 also holds, because the BRAM is not read, so the outputs are bit-stable.
- Latency: fetch issued at edge n is presented from just after edge n until the next issuing edge. Throughput is 1 instruction/cycle when STALL=0.
- Output mapping: IF_IR = (fault_q | !valid_q) ? NOP : MEM_DOUT1. IF_PC=ifpc_q, IF_VALID=valid_q, IF_FAULT=fault_q & valid_q.
- Redirect:
  - Zero-bubble: the target word is presented the cycle after REDIRECT.
  - The instruction presented during the REDIRECT cycle is dropped by the consumer; this block does not re-present it.
- REDIRECT and STALL in the same cycle: REDIRECT wins and the fetch issues.
- A faulting PC still advances sequentially (pc_q = fault PC + 4). The trap redirect from downstream is expected to follow.
- Reset release: the first edge with RST=0 and STALL=0 issues RESET_VEC. IF_VALID rises after that edge.
- STALL held through reset release: nothing issues and IF_VALID stays 0.
- RST asserted mid-stream: all state clears immediately (asynchronous) and MEM_READ1 drops the same cycle.
- PC 32'hFFFF_FFFC+4 wraps to 0. No special handling beyond the access-fault check.

Decomposition:
- Package otter_pkg:
  - NOP_INSTR=32'h0000_0013.
  - Fetch cause enum (FC_MISALIGN=0, FC_ACCESS=1).
  - Default RESET_VEC.
- One optional sub-module, otter_fetch_fault_chk: purely combinational address → {fault, cause}, shared later with the data-side access stage.
- Everything else stays in one module.

Test Plan:
- Reset to RESET_VEC=0 with memory words 0..3 = 32'h11,22,33,44, STALL=0 → MEM_ADDR1 = 0,4,8,C on consecutive cycles; from the first post-reset edge on, IF_PC/IF_IR = (0,0x11),(4,0x22),(8,0x33); IF_VALID high from the cycle after the first issue.
- Assert STALL for 3 cycles while IF_PC=4 → MEM_READ1=0; IF_PC=4, IF_IR=0x22, IF_VALID=1 stable all 3 cycles; resumes at PC=8 the cycle after STALL drops.
- REDIRECT=1, REDIRECT_PC=0x100, STALL=1 in the same cycle → MEM_ADDR1=0x100 that cycle, MEM_READ1=1; next cycle IF_PC=0x100, IF_IR=mem[0x40]; then MEM_ADDR1=0x104.
- Redirect to 0x102 → next cycle IF_FAULT=1, IF_CAUSE=0, IF_IR=NOP, IF_PC=0x102. Redirect to 2**20 (MEM_WIDTH=18) → IF_FAULT=1, IF_CAUSE=1.
- Assert RST asynchronously between edges while IF_VALID=1 → IF_VALID, MEM_READ1 and IF_FAULT fall without a clock edge; after release, fetch restarts at RESET_VEC.
- STALL held high across reset release for 5 cycles → MEM_READ1=0 and IF_VALID=0 throughout; the first issue is RESET_VEC when STALL drops.

Source files
------------

// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared constants and types for the otter fetch path
package otter_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

    typedef enum logic {
        FC_MISALIGN = 1'b0,
        FC_ACCESS   = 1'b1
    } fetch_cause_e;

endpackage

// File: rtl/otter_fetch_fault_chk.sv
// rtl/otter_fetch_fault_chk.sv - combinational address fault classifier (misaligned / out of range)
module otter_fetch_fault_chk
    import otter_pkg::*;
#(
    parameter int MEM_WIDTH = 18
) (
    input  logic [31:0]  addr,
    output logic         fault,
    output fetch_cause_e cause
);

    localparam int BYTE_BITS = MEM_WIDTH + 2;

    logic misalign;
    logic access;

    assign misalign = |addr[1:0];

    // A memory filling the whole 32-bit byte space can never be overrun.
    generate
        if (BYTE_BITS >= 32) begin : g_full_space
            assign access = 1'b0;
        end else begin : g_bounded
            assign access = |addr[31:BYTE_BITS];
        end
    endgenerate

    assign fault = misalign | access;
    assign cause = (!misalign && access) ? FC_ACCESS : FC_MISALIGN;

endmodule

// File: rtl/otter_fetch_stage.sv
// rtl/otter_fetch_stage.sv - instruction fetch: owns the PC, drives BRAM port 1, pairs the word with its PC
module otter_fetch_stage
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter int          MEM_WIDTH = 18
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] MEM_ADDR1,
    output logic        MEM_READ1,
    input  logic [31:0] MEM_DOUT1,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC4,
    output logic [31:0] IF_IR,
    output logic        IF_VALID,
    output logic        IF_FAULT,
    output logic        IF_CAUSE
);

    logic [31:0]  pc_q;
    logic [31:0]  ifpc_q;
    logic         valid_q;
    logic         fault_q;
    fetch_cause_e cause_q;

    logic         issue;
    logic         chk_fault;
    fetch_cause_e chk_cause;

    assign MEM_ADDR1 = REDIRECT ? REDIRECT_PC : pc_q;
    assign issue     = !RST && (REDIRECT || !STALL);
    assign MEM_READ1 = issue;

    otter_fetch_fault_chk #(
        .MEM_WIDTH (MEM_WIDTH)
    ) u_fault_chk (
        .addr  (MEM_ADDR1),
        .fault (chk_fault),
        .cause (chk_cause)
    );

    // When not issuing, BRAM data also holds, so the presented pair stays bit-stable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q    <= RESET_VEC;
            ifpc_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= FC_MISALIGN;
        end else if (issue) begin
            pc_q    <= MEM_ADDR1 + 32'd4;
            ifpc_q  <= MEM_ADDR1;
            valid_q <= 1'b1;
            fault_q <= chk_fault;
            cause_q <= chk_fault ? chk_cause : FC_MISALIGN;
        end
    end

    assign IF_PC    = ifpc_q;
    assign IF_PC4   = ifpc_q + 32'd4;
    assign IF_IR    = (fault_q || !valid_q) ? NOP_INSTR : MEM_DOUT1;
    assign IF_VALID = valid_q;
    assign IF_FAULT = fault_q & valid_q;
    assign IF_CAUSE = cause_q;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// tb/tb_otter_fetch_stage.sv - directed self-checking bench for otter_fetch_stage
module tb_otter_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic [31:0] MEM_DOUT1;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC4;
    logic [31:0] IF_IR;
    logic        IF_VALID;
    logic        IF_FAULT;
    logic        IF_CAUSE;

    logic [31:0] mem [0:255];
    int checks   = 0;
    int failures = 0;

    otter_fetch_stage #(
        .RESET_VEC (32'h0000_0000),
        .MEM_WIDTH (18)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .STALL       (STALL),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .MEM_ADDR1   (MEM_ADDR1),
        .MEM_READ1   (MEM_READ1),
        .MEM_DOUT1   (MEM_DOUT1),
        .IF_PC       (IF_PC),
        .IF_PC4      (IF_PC4),
        .IF_IR       (IF_IR),
        .IF_VALID    (IF_VALID),
        .IF_FAULT    (IF_FAULT),
        .IF_CAUSE    (IF_CAUSE)
    );

    always #5 CLK = ~CLK;

    // One-cycle-latency BRAM read port, small window of the address space
    always @(posedge CLK) begin
        if (MEM_READ1) MEM_DOUT1 <= mem[MEM_ADDR1[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        MEM_DOUT1   = 32'h0;
        RST         = 1'b1;
        STALL       = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;

        #2;
        chk("rst_read1", {31'b0, MEM_READ1}, 32'd0);
        chk("rst_valid", {31'b0, IF_VALID}, 32'd0);
        chk("rst_fault", {31'b0, IF_FAULT}, 32'd0);
        chk("rst_pc", IF_PC, 32'h0);
        chk("rst_ir", IF_IR, 32'h13);
        edge_step();
        edge_step();

        RST = 1'b0;
        #1;
        chk("seq_addr0", MEM_ADDR1, 32'h0);
        chk("seq_read0", {31'b0, MEM_READ1}, 32'd1);
        chk("seq_valid_pre", {31'b0, IF_VALID}, 32'd0);
        edge_step();
        chk("seq_pc0", IF_PC, 32'h0);
        chk("seq_ir0", IF_IR, 32'h11);
        chk("seq_valid0", {31'b0, IF_VALID}, 32'd1);
        chk("seq_pc4_0", IF_PC4, 32'h4);
        chk("seq_addr4", MEM_ADDR1, 32'h4);
        edge_step();
        chk("seq_pc4", IF_PC, 32'h4);
        chk("seq_ir4", IF_IR, 32'h22);
        chk("seq_addr8", MEM_ADDR1, 32'h8);

        STALL = 1'b1;
        #1;
        chk("stall_read", {31'b0, MEM_READ1}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("stall_read_c", {31'b0, MEM_READ1}, 32'd0);
            chk("stall_pc", IF_PC, 32'h4);
            chk("stall_ir", IF_IR, 32'h22);
            chk("stall_valid", {31'b0, IF_VALID}, 32'd1);
        end
        STALL = 1'b0;
        #1;
        chk("resume_addr", MEM_ADDR1, 32'h8);
        edge_step();
        chk("resume_pc", IF_PC, 32'h8);
        chk("resume_ir", IF_IR, 32'h33);
        chk("resume_addr_next", MEM_ADDR1, 32'hC);

        REDIRECT = 1'b1; REDIRECT_PC = 32'h100; STALL = 1'b1;
        #1;
        chk("redir_addr", MEM_ADDR1, 32'h100);
        chk("redir_read", {31'b0, MEM_READ1}, 32'd1);
        edge_step();
        REDIRECT = 1'b0; STALL = 1'b0;
        #1;
        chk("redir_pc", IF_PC, 32'h100);
        chk("redir_ir", IF_IR, 32'hA000_0040);
        chk("redir_fault", {31'b0, IF_FAULT}, 32'd0);
        chk("redir_addr_next", MEM_ADDR1, 32'h104);
        edge_step();
        chk("redir_pc2", IF_PC, 32'h104);
        chk("redir_ir2", IF_IR, 32'hA000_0041);

        REDIRECT = 1'b1; REDIRECT_PC = 32'h102;
        edge_step();
        REDIRECT = 1'b0;
        #1;
        chk("mis_fault", {31'b0, IF_FAULT}, 32'd1);
        chk("mis_cause", {31'b0, IF_CAUSE}, 32'd0);
        chk("mis_ir", IF_IR, 32'h13);
        chk("mis_pc", IF_PC, 32'h102);
        chk("mis_addr_next", MEM_ADDR1, 32'h106);

        REDIRECT = 1'b1; REDIRECT_PC = 32'h0010_0000;
        edge_step();
        REDIRECT = 1'b0;
        #1;
        chk("acc_fault", {31'b0, IF_FAULT}, 32'd1);
        chk("acc_cause", {31'b0, IF_CAUSE}, 32'd1);
        chk("acc_ir", IF_IR, 32'h13);
        chk("acc_pc", IF_PC, 32'h0010_0000);

        REDIRECT = 1'b1; REDIRECT_PC = 32'h000F_FFFC;
        edge_step();
        REDIRECT = 1'b0;
        #1;
        chk("edge_ok_fault", {31'b0, IF_FAULT}, 32'd0);
        chk("edge_ok_addr", MEM_ADDR1, 32'h0010_0000);

        REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC;
        edge_step();
        REDIRECT = 1'b0;
        #1;
        chk("wrap_fault", {31'b0, IF_FAULT}, 32'd1);
        chk("wrap_cause", {31'b0, IF_CAUSE}, 32'd1);
        chk("wrap_pc4", IF_PC4, 32'h0);
        chk("wrap_addr", MEM_ADDR1, 32'h0);
        edge_step();
        chk("wrap_pc", IF_PC, 32'h0);
        chk("wrap_ir", IF_IR, 32'h11);
        chk("wrap_valid", {31'b0, IF_VALID}, 32'd1);

        // Mid-cycle reset must clear outputs with no clock edge
        #2;
        RST = 1'b1;
        #1;
        chk("arst_valid", {31'b0, IF_VALID}, 32'd0);
        chk("arst_read", {31'b0, MEM_READ1}, 32'd0);
        chk("arst_fault", {31'b0, IF_FAULT}, 32'd0);
        chk("arst_ir", IF_IR, 32'h13);
        edge_step();
        RST = 1'b0;
        #1;
        chk("arst_rel_addr", MEM_ADDR1, 32'h0);
        edge_step();
        chk("arst_rel_pc", IF_PC, 32'h0);
        chk("arst_rel_ir", IF_IR, 32'h11);

        RST = 1'b1; STALL = 1'b1;
        edge_step();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            chk("stallrel_read", {31'b0, MEM_READ1}, 32'd0);
            chk("stallrel_valid", {31'b0, IF_VALID}, 32'd0);
        end
        STALL = 1'b0;
        #1;
        chk("stallrel_addr", MEM_ADDR1, 32'h0);
        chk("stallrel_read1", {31'b0, MEM_READ1}, 32'd1);
        edge_step();
        chk("stallrel_pc", IF_PC, 32'h0);
        chk("stallrel_ir", IF_IR, 32'h11);
        chk("stallrel_vld", {31'b0, IF_VALID}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
